wb_picosoc_mem_adapter: RTL
===========================

// Module: wb_picosoc_mem_adapter
// PURPOSE
//  Wishbone B4 pipelined slave that drives a single-port word RAM (byte-lane wen, 1-cycle read).
//  Sits directly upstream of the RAM: translates bus cycles to RAM strobes and returns ack/err/data.
//  Optionally zero-fills the RAM after reset before accepting traffic. Rejects out-of-range addresses.
// PARAMETERS
//  WORDS          256  RAM depth in 32-bit words; legal word addresses 0..WORDS-1
//  ADDR_W         22   width of wb_adr and mem_addr (word address)
//  OUT_REG        0    0: read data/ack 1 cycle after accept; 1: extra output register, 2 cycles
//  CLEAR_ON_RESET 1    1: zero-fill sweep of all WORDS after reset; 0: skip sweep
// PORTS
//  clk        in   1       system clock
//  rst        in   1       asynchronous active-high reset
//  wb_cyc     in   1       bus cycle active
//  wb_stb     in   1       request strobe
//  wb_we      in   1       1 = write
//  wb_sel     in   4       byte lane select
//  wb_adr     in   ADDR_W  word address
//  wb_dat_w   in   32      write data
//  wb_dat_r   out  32      read data, valid with wb_ack
//  wb_ack     out  1       successful completion, one pulse per accepted request
//  wb_err     out  1       error completion (out-of-range address)
//  wb_stall   out  1       request not accepted this cycle
//  mem_wen    out  4       RAM byte write enables
//  mem_addr   out  ADDR_W  RAM word address
//  mem_wdata  out  32      RAM write data
//  mem_rdata  in   32      RAM read data, 1 cycle after mem_addr
// BEHAVIOUR
//  - Reset: wb_ack=0, wb_err=0, wb_dat_r=0, mem_wen=0, wb_stall=CLEAR_ON_RESET, pending pipe cleared.
//  - FSM: CLEAR -> RUN. Reset enters CLEAR if CLEAR_ON_RESET else RUN.
//    CLEAR: clr_cnt 0..WORDS-1, one word/cycle, mem_wen=4'hF, mem_wdata=0, mem_addr=clr_cnt,
//    wb_stall=1; after clr_cnt==WORDS-1 -> RUN (sweep = WORDS cycles). Reset mid-sweep restarts at 0.
//  - RUN: wb_stall=0. accept = wb_cyc & wb_stb & ~wb_stall. in_rng = (wb_adr < WORDS).
//    mem_addr=wb_adr, mem_wdata=wb_dat_w (combinational pass-through, no added latency).
//    mem_wen = (accept & wb_we & in_rng) ? wb_sel : 4'h0. wb_sel=0 write: no RAM change, still acked.
//  - Response pipe: each accept pushes {ok=in_rng, err=~in_rng} into a LAT-deep shift register,
//    LAT = 1+OUT_REG. Exactly one of wb_ack/wb_err pulses LAT cycles after accept; back-to-back
//    accepts give back-to-back responses (one request per cycle, no bubbles).
//  - wb_dat_r: on read ack = mem_rdata captured (OUT_REG=1: registered once more);
//    on write ack and on err = 32'h0.
//  - Read in the cycle after a write to the same word returns the new data (RAM write-then-read);
//    no forwarding needed within a cycle since one request per cycle.
//  - Abort: wb_cyc=0 flushes all pending pipe entries at the next edge; no ack/err emitted
//    for them. Writes already strobed into RAM are not undone.
//  - wb_stb without wb_cyc: ignored. Requests during CLEAR: stalled, not lost, held by master.
//  - Address comparison uses full ADDR_W bits; WORDS need not be a power of two.
// STRUCTURE
//  - Package wb_mem_adapter_pkg: state enum {ST_CLEAR, ST_RUN}; rsp_t struct {ok, err};
//    localparam function for LAT from OUT_REG.
//  - One sub-module: wb_rsp_pipe (parameter DEPTH; push, flush, rsp_t in/out, 32-bit data
//    stage for OUT_REG). Top holds FSM, clear counter, decode, RAM strobe muxing.
// TESTING
//  1. Reset with CLEAR_ON_RESET=1, WORDS=256 -> wb_stall=1 for 256 cycles, mem_wen=F, addrs 0..255
//     with data 0; first accept cycle 257; read adr 0x10 -> wb_dat_r=0.
//  2. Write adr 0x05 data 0xA1B2C3D4 sel=4'b0101, then read 0x05 -> ack at LAT after each,
//     read data 0x00B200D4 (over cleared RAM).
//  3. Burst 8 back-to-back reads adr 0..7 (pre-written i*0x11111111), OUT_REG=1 -> 8 consecutive
//     acks starting 2 cycles after first accept, data in order.
//  4. Read adr=WORDS (256) -> wb_err=1 one cycle later, wb_ack=0, mem_wen=0, wb_dat_r=0;
//     write adr 0x3FFFFF -> err, RAM unchanged.
//  5. Issue 3 reads (OUT_REG=1), drop wb_cyc the cycle after last accept -> at most the first ack
//     already due is seen, none after cyc low; next cycle new read acks normally.
//  6. Assert rst mid-sweep at clr_cnt=100 -> outputs to reset values immediately, sweep restarts at 0,
//     full 256-cycle stall again.

Source files
------------

// File: rtl/wb_picosoc_mem_adapter_pkg.sv
// Shared types and constants for the Wishbone-to-word-RAM adapter.
// The package is named wb_mem_adapter_pkg; every other file imports it.
package wb_mem_adapter_pkg;

    typedef logic [0:0] state_t;

    localparam state_t ST_CLEAR = 1'b0;
    localparam state_t ST_RUN   = 1'b1;

    typedef struct packed {
        logic ok;
        logic err;
    } rsp_t;

    // Response latency in cycles: one RAM read cycle plus the optional output stage.
    function automatic int unsigned lat_of(input int unsigned out_reg);
        return (out_reg != 0) ? 32'd2 : 32'd1;
    endfunction

endpackage

// File: rtl/wb_picosoc_mem_adapter_rsp_pipe.sv
// Fixed-latency response pipe.
// Every cycle it shifts in either an accepted request's ok/err tag or an empty slot, and it carries the read data alongside.
module wb_rsp_pipe
    import wb_mem_adapter_pkg::*;
#(
    parameter int unsigned DEPTH = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic        flush,
    input  logic        rd,
    input  rsp_t        rsp_in,
    input  logic [31:0] rdata,
    output rsp_t        rsp_out,
    output logic [31:0] rdata_out
);

    logic [DEPTH-1:0] ok_q;
    logic [DEPTH-1:0] err_q;
    logic             rd_q;
    logic [31:0]      rdata_cap_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ok_q  <= '0;
            err_q <= '0;
            rd_q  <= 1'b0;
        end else if (flush) begin
            ok_q  <= '0;
            err_q <= '0;
            rd_q  <= 1'b0;
        end else begin
            ok_q  <= DEPTH'({ok_q, push & rsp_in.ok});
            err_q <= DEPTH'({err_q, push & rsp_in.err});
            rd_q  <= push & rd;
        end
    end

    // RAM data is valid while the accepted read sits in stage 0; zero for writes and errors.
    assign rdata_cap_c = (ok_q[0] & rd_q) ? rdata : 32'h0;

    always_comb begin
        rsp_out.ok  = ok_q[DEPTH-1];
        rsp_out.err = err_q[DEPTH-1];
    end

    generate
        if (DEPTH == 1) begin : g_out_comb
            assign rdata_out = rdata_cap_c;
        end else begin : g_out_reg
            localparam int unsigned DW = 32 * (DEPTH - 1);
            logic [DW-1:0] dat_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    dat_q <= '0;
                end else if (flush) begin
                    dat_q <= '0;
                end else begin
                    dat_q <= DW'({dat_q, rdata_cap_c});
                end
            end

            assign rdata_out = dat_q[DW-1 -: 32];
        end
    endgenerate

endmodule

// File: rtl/wb_picosoc_mem_adapter.sv
// Wishbone B4 pipelined slave in front of a single-port word RAM.
// It can zero-fill the RAM after reset, and it answers out-of-range addresses with wb_err.
module wb_picosoc_mem_adapter
    import wb_mem_adapter_pkg::*;
#(
    parameter int unsigned WORDS          = 256,
    parameter int unsigned ADDR_W         = 22,
    parameter int unsigned OUT_REG        = 0,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_cyc,
    input  logic              wb_stb,
    input  logic              wb_we,
    input  logic [3:0]        wb_sel,
    input  logic [ADDR_W-1:0] wb_adr,
    input  logic [31:0]       wb_dat_w,
    output logic [31:0]       wb_dat_r,
    output logic              wb_ack,
    output logic              wb_err,
    output logic              wb_stall,
    output logic [3:0]        mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int unsigned       LAT        = lat_of(OUT_REG);
    localparam logic [ADDR_W-1:0] LAST_WORD  = ADDR_W'(WORDS - 1);
    localparam logic [ADDR_W:0]   WORDS_EXT  = (ADDR_W + 1)'(WORDS);
    localparam state_t            RESET_ST   = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] clr_cnt;
    logic [ADDR_W-1:0] clr_cnt_nxt;
    logic              clearing;
    logic              in_rng;
    logic              accept;
    rsp_t              rsp_push;
    rsp_t              rsp_pop;
    logic [31:0]       pipe_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= RESET_ST;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    // Clear sweep writes one word per cycle, then hands over to normal traffic.
    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        if (state == ST_CLEAR) begin
            if (clr_cnt == LAST_WORD) begin
                state_nxt = ST_RUN;
            end else begin
                clr_cnt_nxt = clr_cnt + ADDR_W'(1);
            end
        end
    end

    assign clearing = (state == ST_CLEAR);
    assign wb_stall = clearing;
    assign accept   = wb_cyc & wb_stb & ~clearing;
    // Zero-extended compare so WORDS may equal 2**ADDR_W or be any non-power-of-two.
    assign in_rng   = ({1'b0, wb_adr} < WORDS_EXT);

    always_comb begin
        mem_wen   = 4'h0;
        mem_addr  = wb_adr;
        mem_wdata = wb_dat_w;
        if (rst) begin
            mem_wen = 4'h0;
        end else if (clearing) begin
            mem_wen   = 4'hF;
            mem_addr  = clr_cnt;
            mem_wdata = 32'h0;
        end else if (accept && wb_we && in_rng) begin
            mem_wen = wb_sel;
        end
    end

    always_comb begin
        rsp_push.ok  = in_rng;
        rsp_push.err = ~in_rng;
    end

    wb_rsp_pipe #(
        .DEPTH (LAT)
    ) u_rsp_pipe (
        .clk       (clk),
        .rst       (rst),
        .push      (accept),
        .flush     (~wb_cyc),
        .rd        (~wb_we),
        .rsp_in    (rsp_push),
        .rdata     (mem_rdata),
        .rsp_out   (rsp_pop),
        .rdata_out (pipe_rdata)
    );

    // A master that has dropped wb_cyc never sees a completion for an aborted cycle.
    assign wb_ack   = rsp_pop.ok & wb_cyc;
    assign wb_err   = rsp_pop.err & wb_cyc;
    assign wb_dat_r = wb_ack ? pipe_rdata : 32'h0;

endmodule
